// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_loader
// Purpose  : Collects N coefficient beats in a shadow bank and commits them
//            atomically onto the FIR tap-weight bus h.
// Revision : 1.0
// ============================================================================
module fir_coeff_loader #(
  parameter int N           = 4,
  parameter int COEFF_WIDTH = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start,
  input  logic [COEFF_WIDTH-1:0]     coeff_in,
  input  logic                       coeff_valid,
  output logic                       coeff_ready,
  output logic [N*COEFF_WIDTH-1:0]   h,
  output logic                       busy,
  output logic                       done,
  output logic                       abort,
  output logic [CNT_WIDTH-1:0]       commit_cnt
);

  localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                    r_state;
  logic [c_IDX_W-1:0]        r_idx;
  logic [COEFF_WIDTH-1:0]    r_shadow [N];
  logic [N*COEFF_WIDTH-1:0]  r_h;
  logic                      r_done;
  logic                      r_abort;
  logic [CNT_WIDTH-1:0]      r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_h     <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
          end
        end
        S_LOAD: begin
          // A restart wins over a beat presented on the same edge.
          if (start) begin
            r_idx   <= '0;
            r_abort <= 1'b1;
          end else if (coeff_valid) begin
            r_shadow[r_idx] <= coeff_in;
            if (r_idx == c_LAST_IDX) begin
              r_idx   <= '0;
              r_state <= S_COMMIT;
            end else begin
              r_idx <= r_idx + c_IDX_W'(1);
            end
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < N; k++) begin
            r_h[k*COEFF_WIDTH +: COEFF_WIDTH] <= r_shadow[k];
          end
          r_done  <= 1'b1;
          r_cnt   <= r_cnt + CNT_WIDTH'(1);
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign coeff_ready = (r_state == S_LOAD);
  assign busy        = (r_state == S_LOAD) || (r_state == S_COMMIT);
  assign h           = r_h;
  assign done        = r_done;
  assign abort       = r_abort;
  assign commit_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_loader
// Purpose  : Directed plus random stimulus against a queue-based loader model.
// Revision : 1.0
// ============================================================================
module tb_fir_coeff_loader;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    coeff_in = '0;
  logic            coeff_valid = 1'b0;
  logic            coeff_ready;
  logic [N*W-1:0]  h;
  logic            busy;
  logic            done;
  logic            abort;
  logic [CW-1:0]   commit_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  // Behavioural model: a loading/commit-pending flag pair and a beat queue.
  logic            m_loading = 1'b0;
  logic            m_pend    = 1'b0;
  logic [W-1:0]    m_q[$];
  logic [N*W-1:0]  m_h = '0;
  int              m_cnt = 0;
  logic            m_done = 1'b0;
  logic            m_abort = 1'b0;

  fir_coeff_loader #(.N(N), .COEFF_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .coeff_in    (coeff_in),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .h           (h),
    .busy        (busy),
    .done        (done),
    .abort       (abort),
    .commit_cnt  (commit_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic v, input logic [W-1:0] c, input logic rn);
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (!rn) begin
      m_loading = 1'b0;
      m_pend    = 1'b0;
      m_q.delete();
      m_h   = '0;
      m_cnt = 0;
    end else if (m_pend) begin
      for (int k = 0; k < N; k++) m_h[k*W +: W] = m_q[k];
      m_q.delete();
      m_pend = 1'b0;
      m_done = 1'b1;
      m_cnt  = (m_cnt + 1) % (1 << CW);
    end else if (m_loading) begin
      if (s) begin
        m_q.delete();
        m_abort = 1'b1;
      end else if (v) begin
        m_q.push_back(c);
        if (m_q.size() == N) begin
          m_loading = 1'b0;
          m_pend    = 1'b1;
        end
      end
    end else if (s) begin
      m_loading = 1'b1;
      m_q.delete();
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [W-1:0] c, input logic rn);
    start = s; coeff_valid = v; coeff_in = c; RST_N = rn;
    @(posedge CLK);
    #1;
    model_step(s, v, c, rn);
    check("h", 64'(h), 64'(m_h));
    check("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
    check("coeff_ready", 64'(coeff_ready), 64'(m_loading));
    check("busy", 64'(busy), 64'(m_loading | m_pend));
    check("done", 64'(done), 64'(m_done));
    check("abort", 64'(abort), 64'(m_abort));
  endtask

  task automatic full_load(input logic [N*W-1:0] val);
    cyc(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, val[k*W +: W], 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [N*W-1:0] rv;
    int cnt0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1'($urandom), 1'($urandom), W'($urandom), 1'b0);
    check("rst_h", 64'(h), 64'h0);
    check("rst_cnt", 64'(commit_cnt), 64'h0);
    check("rst_ready", 64'(coeff_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);

    // Full-rate load: h updates exactly 5 edges after start
    cyc(1'b1, 1'b0, '0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b1, W'(k), 1'b1);
      check("fr_h_hold", 64'(h), 64'h0);
    end
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("fr_h", 64'(h), 64'h4321);
    check("fr_done", 64'(done), 64'h1);
    check("fr_cnt", 64'(commit_cnt), 64'h1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("fr_done_once", 64'(done), 64'h0);

    // Commit FFFF, then a stalled load of 1,2,3,4
    full_load(16'hFFFF);
    check("ffff_h", 64'(h), 64'hFFFF);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 4'h1, 1'b1);
    cyc(1'b0, 1'b1, 4'h2, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, W'($urandom), 1'b1);
    cyc(1'b0, 1'b1, 4'h3, 1'b1);
    cyc(1'b0, 1'b1, 4'h4, 1'b1);
    check("stall_h_hold", 64'(h), 64'hFFFF);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("stall_h", 64'(h), 64'h4321);

    // Abort: restart with a simultaneous beat of 9, which is dropped
    full_load(16'hFFFF);
    cnt0 = int'(commit_cnt);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 4'h5, 1'b1);
    cyc(1'b0, 1'b1, 4'h6, 1'b1);
    cyc(1'b1, 1'b1, 4'h9, 1'b1);
    check("ab_abort", 64'(abort), 64'h1);
    check("ab_h_hold", 64'(h), 64'hFFFF);
    cyc(1'b0, 1'b1, 4'hA, 1'b1);
    check("ab_abort_once", 64'(abort), 64'h0);
    cyc(1'b0, 1'b1, 4'hB, 1'b1);
    cyc(1'b0, 1'b1, 4'hC, 1'b1);
    cyc(1'b0, 1'b1, 4'hD, 1'b1);
    check("ab_h_hold2", 64'(h), 64'hFFFF);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("ab_h", 64'(h), 64'hDCBA);
    check("ab_cnt", 64'(commit_cnt), 64'((cnt0 + 1) % 256));

    // Mid-load reset
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 4'h1, 1'b1);
    cyc(1'b0, 1'b1, 4'h2, 1'b1);
    cyc(1'($urandom), 1'($urandom), W'($urandom), 1'b0);
    check("mr_h", 64'(h), 64'h0);
    check("mr_busy", 64'(busy), 64'h0);
    full_load(16'h7777);
    check("mr_h2", 64'(h), 64'h7777);
    check("mr_cnt", 64'(commit_cnt), 64'h1);

    // coeff_valid in IDLE is ignored
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, W'($urandom), 1'b1);
    check("idle_h", 64'(h), 64'h7777);
    check("idle_ready", 64'(coeff_ready), 64'h0);

    // start during COMMIT is ignored
    cyc(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, 4'h2, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    check("cs_h", 64'(h), 64'h2222);
    cyc(1'b0, 1'b1, 4'h5, 1'b1);
    check("cs_busy", 64'(busy), 64'h0);
    check("cs_ready", 64'(coeff_ready), 64'h0);

    // Back-to-back loads until the commit counter wraps
    while (m_cnt != 255) begin
      rv = N*W'($urandom);
      full_load(rv);
    end
    rv = N*W'($urandom);
    full_load(rv);
    check("wrap_cnt", 64'(commit_cnt), 64'h0);
    check("wrap_done", 64'(done), 64'h1);
    check("wrap_h", 64'(h), 64'(rv));

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) == 0), 1'($urandom), W'($urandom),
          ($urandom_range(0, 60) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
